// File: rtl/fetch_aligner.sv
// fetch_aligner
//   Instruction-stream aligner between fetch and decode of an RV32IC core.
//   Takes 32-bit word-aligned fetch words, keeps up to three halfwords, and
//   emits one 16-bit (compressed) or 32-bit instruction per handshake.
//   Handles 32-bit instructions straddling a word boundary and redirect
//   targets that land on the upper halfword of a word.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   redirect_i/_pc_i     flush and restart at redirect_pc_i (bit 0 ignored)
//   fetch_valid_i        fetch_data_i carries the next sequential word
//   fetch_ready_o        aligner takes the word this cycle (registered-state only)
//   fetch_data_i         word; [15:0] is the lower-address halfword
//   instr_valid_o        instr_o holds a complete instruction
//   instr_ready_i        decoder consumes the instruction this cycle
//   instr_o              instruction; compressed form in [15:0], upper zero
//   instr_pc_o           address of instr_o
//   instr_compressed_o   instr_o[1:0] != 2'b11
//   instr_illegal_o      valid compressed all-zero halfword
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        instr_illegal_o
);

  // hb_q[0] is the oldest halfword; pc_q is its address.
  logic [2:0][15:0] hb_q, hb_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             skip_q, skip_d;

  logic             is32;
  logic             fire_i, fire_f;
  logic [1:0]       n_cons;
  logic [1:0]       n_app;
  logic [1:0]       base;

  // Accept only when the post-consume buffer can take a full word in any
  // case; this keeps fetch_ready_o independent of the decoder handshake.
  assign fetch_ready_o = (cnt_q <= 2'd1);

  assign is32          = (hb_q[0][1:0] == 2'b11);
  assign instr_valid_o = is32 ? (cnt_q >= 2'd2) : (cnt_q >= 2'd1);
  assign instr_o       = is32 ? {hb_q[1], hb_q[0]} : {16'h0000, hb_q[0]};
  assign instr_pc_o    = pc_q;
  assign instr_compressed_o = ~is32;
  assign instr_illegal_o    = instr_valid_o & ~is32 & (hb_q[0] == 16'h0000);

  // Redirect wins: neither handshake has any effect in its cycle.
  assign fire_i = instr_valid_o & instr_ready_i & ~redirect_i;
  assign fire_f = fetch_valid_i & fetch_ready_o & ~redirect_i;

  always_comb begin
    hb_d   = hb_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    skip_d = skip_q;
    n_cons = 2'd0;
    n_app  = 2'd0;

    if (fire_i) n_cons = is32 ? 2'd2 : 2'd1;

    // Shift out consumed halfwords first.
    case (n_cons)
      2'd1:    hb_d = {16'h0000, hb_q[2], hb_q[1]};
      2'd2:    hb_d = {32'h0000_0000, hb_q[2]};
      default: hb_d = hb_q;
    endcase

    // Then append behind what remains. Accept implies cnt_q <= 1, so the
    // remaining count is 0 or 1 and the word always fits.
    base = cnt_q - n_cons;
    if (fire_f) begin
      if (skip_q) begin
        // First word after a halfword-aligned redirect: low half is not ours.
        n_app = 2'd1;
        if (base[0]) hb_d[1] = fetch_data_i[31:16];
        else         hb_d[0] = fetch_data_i[31:16];
      end else begin
        n_app = 2'd2;
        if (base[0]) begin
          hb_d[1] = fetch_data_i[15:0];
          hb_d[2] = fetch_data_i[31:16];
        end else begin
          hb_d[0] = fetch_data_i[15:0];
          hb_d[1] = fetch_data_i[31:16];
        end
      end
      skip_d = 1'b0;
    end

    cnt_d = base + n_app;
    pc_d  = pc_q + {29'd0, n_cons, 1'b0};

    if (redirect_i) begin
      hb_d   = '0;
      cnt_d  = 2'd0;
      pc_d   = {redirect_pc_i[31:1], 1'b0};
      skip_d = redirect_pc_i[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q   <= '0;
      cnt_q  <= 2'd0;
      pc_q   <= {RESET_PC[31:1], 1'b0};
      skip_q <= RESET_PC[1];
    end else begin
      hb_q   <= hb_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: stimulus pushes expected instructions,
// a negedge monitor pops and compares on every output handshake.
module tb_fetch_aligner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_illegal_o;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_data_i(fetch_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_compressed_o(instr_compressed_o), .instr_illegal_o(instr_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic c, input logic ill);
    exp_t x;
    x.instr = instr; x.pc = pc; x.c = c; x.ill = ill;
    sb.push_back(x);
  endtask

  always @(posedge clk)
    if (rst_n && fetch_valid_i && fetch_ready_o && !redirect_i) accepts <= accepts + 1;

  always @(negedge clk) begin
    if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got %h at pc %h, expected none", instr_o, instr_pc_o);
      end else begin
        e = sb.pop_front();
        chk("instr", instr_o, e.instr);
        chk("instr_pc", instr_pc_o, e.pc);
        chk("compressed", {31'd0, instr_compressed_o}, {31'd0, e.c});
        chk("illegal", {31'd0, instr_illegal_o}, {31'd0, e.ill});
      end
    end
  end

  // Present a word and hold it until the aligner takes it (bounded).
  task automatic send_word(input logic [31:0] w);
    bit ok = 0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (fetch_ready_o) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: word %h not accepted, expected accept", w);
    end
    @(posedge clk); #1;
    fetch_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_i = 1'b0;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, expected finish");
    $fatal(1);
  end

  initial begin
    int a0;
    // Reset state, sampled before any clock edge.
    #2;
    chk("rst_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_compressed", {31'd0, instr_compressed_o}, 32'd1);
    chk("rst_illegal", {31'd0, instr_illegal_o}, 32'd0);

    // Aligned compressed pair.
    do_reset();
    push(32'h0000_0505, 32'h0, 1'b1, 1'b0);
    push(32'h0000_4505, 32'h2, 1'b1, 1'b0);
    send_word(32'h4505_0505);
    chk("pair_ready_c1", {31'd0, fetch_ready_o}, 32'd0);
    chk("pair_valid_c1", {31'd0, instr_valid_o}, 32'd1);
    @(posedge clk); #1;
    chk("pair_ready_c2", {31'd0, fetch_ready_o}, 32'd1);
    wait_drain();

    // Straddling 32-bit instruction.
    do_reset();
    push(32'h0000_0001, 32'h0, 1'b1, 1'b0);
    push(32'h0010_0093, 32'h2, 1'b0, 1'b0);
    push(32'h0000_1234, 32'h6, 1'b1, 1'b0);
    send_word(32'h0093_0001);
    send_word(32'h1234_0010);
    wait_drain();

    // Halfword-aligned redirect: low half of the first word is skipped.
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    chk("redir_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("redir_pc", instr_pc_o, 32'h0000_0102);
    push(32'h0000_4505, 32'h0000_0102, 1'b1, 1'b0);
    send_word(32'h4505_FFFF);
    wait_drain();
    @(posedge clk); #1;
    chk("redir_no_extra", {31'd0, instr_valid_o}, 32'd0);

    // Backpressure: decoder stalled 5 cycles while 3 words are offered.
    do_reset();
    instr_ready_i = 1'b0;
    push(32'h0000_1111, 32'h0, 1'b1, 1'b0);
    push(32'h0000_2222, 32'h2, 1'b1, 1'b0);
    push(32'h0000_3331, 32'h4, 1'b1, 1'b0);
    push(32'h0000_4444, 32'h6, 1'b1, 1'b0);
    push(32'h0000_5555, 32'h8, 1'b1, 1'b0);
    push(32'h0000_6666, 32'ha, 1'b1, 1'b0);
    a0 = accepts;
    fork
      begin
        send_word(32'h2222_1111);
        send_word(32'h4444_3331);
        send_word(32'h6666_5555);
      end
      begin
        repeat (5) begin
          @(posedge clk); #2;
          chk("bp_instr_stable", instr_o, 32'h0000_1111);
          chk("bp_pc_stable", instr_pc_o, 32'h0);
        end
        chk("bp_accepts", accepts - a0, 32'd1);
        chk("bp_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
        instr_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Illegal flag, then redirect in the same cycle as an offered word.
    do_reset();
    push(32'h0000_0000, 32'h0, 1'b1, 1'b1);
    send_word(32'h0000_0000);
    chk("ill_flag", {31'd0, instr_illegal_o}, 32'd1);
    chk("ill_valid", {31'd0, instr_valid_o}, 32'd1);
    @(posedge clk); #1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0040;
    fetch_valid_i = 1'b1;
    fetch_data_i = 32'h4505_0505;
    chk("prio_ready_in_cycle", {31'd0, fetch_ready_o}, 32'd1);
    @(posedge clk); #1;
    redirect_i = 1'b0;
    fetch_valid_i = 1'b0;
    chk("prio_valid_after", {31'd0, instr_valid_o}, 32'd0);
    chk("prio_pc_after", instr_pc_o, 32'h0000_0040);
    chk("prio_ready_after", {31'd0, fetch_ready_o}, 32'd1);
    push(32'h0000_1111, 32'h0000_0040, 1'b1, 1'b0);
    push(32'h0000_2222, 32'h0000_0042, 1'b1, 1'b0);
    send_word(32'h2222_1111);
    wait_drain();

    // Asynchronous reset with a partial 32-bit instruction buffered.
    do_reset();
    push(32'h0000_0001, 32'h0, 1'b1, 1'b0);
    send_word(32'h0093_0001);
    wait_drain();
    chk("partial_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("partial_compressed", {31'd0, instr_compressed_o}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
    chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("arst_instr", instr_o, 32'h0);
    chk("arst_pc", instr_pc_o, 32'h0);
    chk("arst_compressed", {31'd0, instr_compressed_o}, 32'd1);
    chk("arst_illegal", {31'd0, instr_illegal_o}, 32'd0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
